// File: rtl/irq_arbiter.sv
// ============================================================================
// Module      : irq_arbiter
// Description : Shares one processor IRQ raise/ack pair among NUM_SRC bus
//               peripherals. Provides MASK/PENDING/VECTOR/EOI registers on
//               the 8-bit memory bus. Define IRQ_ROUND_ROBIN_EN for rotating
//               priority; otherwise fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module irq_arbiter #(
    parameter int          NUM_SRC   = 4,
    parameter logic [7:0]  BASE_ADDR = 8'hD0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_IRQ_RAISE,
    output logic [NUM_SRC-1:0] SRC_IRQ_ACK,
    output logic               CPU_IRQ_RAISE,
    input  logic               CPU_IRQ_ACK
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RAISE   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

    logic [NUM_SRC-1:0] raise_prev_q, raise_prev_d;
    logic [NUM_SRC-1:0] pending_q,    pending_d;
    logic [NUM_SRC-1:0] mask_q,       mask_d;
    logic [NUM_SRC-1:0] src_ack_q,    src_ack_d;
    logic               armed_q,      armed_d;
    logic [1:0]         state_q,      state_d;
    logic [2:0]         active_q,     active_d;
    logic               valid_q,      valid_d;
    logic               rd_en_q,      rd_en_d;
    logic [7:0]         rd_data_q,    rd_data_d;

    logic [7:0]         addr_off;
    logic               in_window;
    logic               wr_mask;
    logic               wr_eoi;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] eoi_clr;
    logic [7:0]         eoi_clr8;
    logic [7:0]         mask8;
    logic [7:0]         pending8;
    logic [2:0]         win_idx;
    logic               win_found;

    // Wrapping subtract keeps the window test correct for any BASE_ADDR.
    always_comb begin
        addr_off  = BUS_ADDR - BASE_ADDR;
        in_window = (addr_off < 8'd4);
        wr_mask   = BUS_WE && in_window && (addr_off[1:0] == REG_MASK);
        wr_eoi    = BUS_WE && in_window && (addr_off[1:0] == REG_EOI);
    end

    // The first cycle after reset only loads the history, so a level held
    // through reset is not mistaken for a new edge.
    always_comb begin
        raise_prev_d = SRC_IRQ_RAISE;
        armed_d      = 1'b1;
        src_edge     = armed_q ? (SRC_IRQ_RAISE & ~raise_prev_q) : '0;
        src_ack_d    = src_edge;
        eligible     = pending_q & mask_q;
    end

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;
    logic [7:0] elig8;
    int         search;
    logic [2:0] sel;

    always_comb begin
        elig8              = '0;
        elig8[NUM_SRC-1:0] = eligible;
        win_found          = 1'b0;
        win_idx            = '0;
        search             = 0;
        sel                = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            search = int'(last_q) + 1 + k;
            if (search >= NUM_SRC) begin
                search = search - NUM_SRC;
            end
            sel = 3'(search);
            if (!win_found && elig8[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_q <= 3'(NUM_SRC - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        valid_d  = valid_q;
        eoi_clr8 = '0;
`ifdef IRQ_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    active_d = win_idx;
                    valid_d  = 1'b1;
                    state_d  = ST_RAISE;
`ifdef IRQ_ROUND_ROBIN_EN
                    last_d   = win_idx;
`endif
                end
            end
            ST_RAISE: begin
                if (CPU_IRQ_ACK) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    eoi_clr8 = 8'd1 << active_q;
                    active_d = '0;
                    valid_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        eoi_clr = eoi_clr8[NUM_SRC-1:0];
        // A new edge overrides a same-cycle EOI clear.
        pending_d = (pending_q & ~eoi_clr) | src_edge;
        mask_d    = wr_mask ? BUS_DATA[NUM_SRC-1:0] : mask_q;
    end

    always_comb begin
        mask8                 = '0;
        mask8[NUM_SRC-1:0]    = mask_q;
        pending8              = '0;
        pending8[NUM_SRC-1:0] = pending_q;
        rd_en_d               = !BUS_WE && in_window;
        case (addr_off[1:0])
            REG_MASK:    rd_data_d = mask8;
            REG_PENDING: rd_data_d = pending8;
            REG_VECTOR:  rd_data_d = {valid_q, 4'b0000, active_q};
            default:     rd_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            raise_prev_q <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            src_ack_q    <= '0;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            active_q     <= '0;
            valid_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            raise_prev_q <= raise_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            src_ack_q    <= src_ack_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            active_q     <= active_d;
            valid_q      <= valid_d;
            rd_en_q      <= rd_en_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign SRC_IRQ_ACK   = src_ack_q;
    assign CPU_IRQ_RAISE = (state_q == ST_RAISE);
    assign BUS_DATA      = rd_en_q ? rd_data_q : 8'hzz;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// Module      : tb_irq_arbiter
// Description : Directed self-checking bench for irq_arbiter (NUM_SRC=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_irq_arbiter;

    localparam logic [7:0] A_MASK = 8'hD0;
    localparam logic [7:0] A_PEND = 8'hD1;
    localparam logic [7:0] A_VEC  = 8'hD2;
    localparam logic [7:0] A_EOI  = 8'hD3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [3:0] src_raise;
    logic [3:0] src_ack;
    logic       cpu_raise;
    logic       cpu_ack;
    logic [7:0] tb_drv;
    logic       tb_drv_en;
    tri1  [7:0] bus_data;

    int checks = 0;
    int errors = 0;
    int first_idx;
    int second_idx;
    int n;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Undriven bus floats to 8'hFF through the pull-up net type.
    assign bus_data = tb_drv_en ? tb_drv : 8'hzz;

    irq_arbiter #(.NUM_SRC(4), .BASE_ADDR(8'hD0)) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .BUS_ADDR      (bus_addr),
        .BUS_DATA      (bus_data),
        .BUS_WE        (bus_we),
        .SRC_IRQ_RAISE (src_raise),
        .SRC_IRQ_ACK   (src_ack),
        .CPU_IRQ_RAISE (cpu_raise),
        .CPU_IRQ_ACK   (cpu_ack)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        exp_t e;
        step();
        bus_addr = a;
        bus_we   = 1'b0;
        e.tag    = tag;
        e.exp    = exp;
        sb.push_back(e);
        step();
        bus_addr = 8'h00;
        samp();
        e = sb.pop_front();
        check(e.tag, bus_data, e.exp);
        step();
        samp();
        check({tag, "_released"}, bus_data, 8'hFF);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        step();
        bus_addr  = a;
        bus_we    = 1'b1;
        tb_drv    = d;
        tb_drv_en = 1'b1;
        step();
        bus_we    = 1'b0;
        tb_drv_en = 1'b0;
        bus_addr  = 8'h00;
    endtask

    task automatic cpu_ack_pulse();
        step();
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus_addr  = 8'h00;
        bus_we    = 1'b0;
        src_raise = 4'b0000;
        cpu_ack   = 1'b0;
        tb_drv    = 8'h00;
        tb_drv_en = 1'b0;

        // Reset state and register defaults
        repeat (3) step();
        samp();
        check("rst_cpu_raise", {7'd0, cpu_raise}, 8'h00);
        check("rst_src_ack", {4'd0, src_ack}, 8'h00);
        check("rst_bus_released", bus_data, 8'hFF);
        step();
        rst_n = 1'b1;
        step();
        step();
        bus_read(A_MASK, 8'h0F, "rd_mask_reset");
        bus_read(A_PEND, 8'h00, "rd_pend_reset");
        bus_read(A_VEC,  8'h00, "rd_vec_reset");
        bus_read(A_EOI,  8'h00, "rd_eoi_reads_zero");
        bus_read(8'hE0,  8'hFF, "rd_outside_window");

        // Single source handshake
        step();
        src_raise = 4'b0100;
        samp();
        check("t2_ack_cycle_n", {4'd0, src_ack}, 8'h00);
        step();
        samp();
        check("t2_ack_cycle_n1", {4'd0, src_ack}, 8'h04);
        check("t2_raise_cycle_n1", {7'd0, cpu_raise}, 8'h00);
        step();
        src_raise = 4'b0000;
        samp();
        check("t2_ack_cycle_n2", {4'd0, src_ack}, 8'h00);
        check("t2_raise_cycle_n2", {7'd0, cpu_raise}, 8'h01);
        step();
        samp();
        check("t2_raise_hold", {7'd0, cpu_raise}, 8'h01);
        cpu_ack_pulse();
        samp();
        check("t2_raise_drop", {7'd0, cpu_raise}, 8'h00);
        bus_read(A_VEC,  8'h82, "t2_vector");
        bus_read(A_PEND, 8'h04, "t2_pending");
        bus_write(A_EOI, 8'hA5);
        bus_read(A_PEND, 8'h00, "t2_pend_after_eoi");
        bus_read(A_VEC,  8'h00, "t2_vec_after_eoi");
        check("t2_idle_no_raise", {7'd0, cpu_raise}, 8'h00);

        // Two simultaneous sources
`ifdef IRQ_ROUND_ROBIN_EN
        first_idx  = 3;
        second_idx = 1;
`else
        first_idx  = 1;
        second_idx = 3;
`endif
        step();
        src_raise = 4'b1010;
        step();
        samp();
        check("t3_ack_both", {4'd0, src_ack}, 8'h0A);
        step();
        src_raise = 4'b0000;
        samp();
        check("t3_raise", {7'd0, cpu_raise}, 8'h01);
        bus_read(A_VEC, 8'h80 | 8'(first_idx), "t3_vec_first");
        cpu_ack_pulse();
        bus_write(A_EOI, 8'h00);
        samp();
        check("t3_gap_after_eoi", {7'd0, cpu_raise}, 8'h00);
        step();
        samp();
        check("t3_second_raise", {7'd0, cpu_raise}, 8'h01);
        bus_read(A_VEC,  8'h80 | 8'(second_idx), "t3_vec_second");
        bus_read(A_PEND, 8'(1 << second_idx), "t3_pend_second");
        cpu_ack_pulse();
        bus_write(A_EOI, 8'h00);
        bus_read(A_PEND, 8'h00, "t3_pend_cleared");

        // Masked source accumulates; unmask releases it
        bus_write(A_MASK, 8'h0E);
        step();
        src_raise = 4'b0001;
        step();
        step();
        src_raise = 4'b0000;
        repeat (2) step();
        samp();
        check("t4_masked_no_raise", {7'd0, cpu_raise}, 8'h00);
        bus_read(A_PEND, 8'h01, "t4_pend_masked");
        bus_read(A_MASK, 8'h0E, "t4_mask_readback");
        bus_write(A_MASK, 8'h0F);
        samp();
        n = 0;
        while (!cpu_raise && n < 2) begin
            step();
            samp();
            n++;
        end
        check("t4_unmask_raise", {7'd0, cpu_raise}, 8'h01);

        // EOI during RAISE is ignored
        bus_write(A_EOI, 8'hFF);
        samp();
        check("t5_eoi_in_raise_ignored", {7'd0, cpu_raise}, 8'h01);
        bus_read(A_PEND, 8'h01, "t5_pend_unchanged");
        cpu_ack_pulse();
        samp();
        check("t5_service", {7'd0, cpu_raise}, 8'h00);

        // Source edge coincident with its EOI: set wins
        step();
        bus_addr  = A_EOI;
        bus_we    = 1'b1;
        tb_drv    = 8'h00;
        tb_drv_en = 1'b1;
        src_raise = 4'b0001;
        samp();
        check("t5_ack_before", {4'd0, src_ack}, 8'h00);
        step();
        bus_we    = 1'b0;
        tb_drv_en = 1'b0;
        bus_addr  = 8'h00;
        samp();
        check("t5_fresh_ack", {4'd0, src_ack}, 8'h01);
        check("t5_idle_gap", {7'd0, cpu_raise}, 8'h00);
        step();
        src_raise = 4'b0000;
        samp();
        check("t5_reraise", {7'd0, cpu_raise}, 8'h01);
        bus_read(A_PEND, 8'h01, "t5_pend_kept");
        bus_read(A_VEC,  8'h80, "t5_vec_src0");

        // Asynchronous reset while raised
        step();
        src_raise = 4'b0010;
        step();
        step();
        samp();
        check("t6_raise_before_reset", {7'd0, cpu_raise}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", {7'd0, cpu_raise}, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            samp();
            check("t6_no_retrigger_ack", {4'd0, src_ack}, 8'h00);
            check("t6_no_retrigger_raise", {7'd0, cpu_raise}, 8'h00);
        end
        bus_read(A_PEND, 8'h00, "t6_pend_after_reset");
        step();
        src_raise = 4'b0000;
        step();
        src_raise = 4'b0010;
        step();
        samp();
        check("t6_new_edge_ack", {4'd0, src_ack}, 8'h02);
        step();
        samp();
        check("t6_new_edge_raise", {7'd0, cpu_raise}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Shares the processor's single timer-class interrupt line among up to 8 bus peripherals (IR, mouse, timer-derived sources).
- Latches each peripheral's raise, completes that peripheral's raise/ack handshake locally and selects one source.
- Presents the selected source to the Processor through the standard IRQ raise/ack pair.
- Exposes mask, pending, vector and end-of-interrupt (EOI) registers on the 8-bit memory bus so the ISR can identify and retire the source.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- BASE_ADDR, 8'hD0, base of the 4-byte register window (D0..D3).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- BUS_ADDR  input  8  bus address.
- BUS_DATA  inout  8  bus data; driven only during this block's read cycles, Z otherwise.
- BUS_WE  input  1  bus write enable.
- SRC_IRQ_RAISE  input  NUM_SRC  per-source raise; level held by the source until acked.
- SRC_IRQ_ACK  output  NUM_SRC  per-source one-cycle ack pulse.
- CPU_IRQ_RAISE  output  1  to Processor BUS_INTERRUPTS_RAISE bit.
- CPU_IRQ_ACK  input  1  from Processor BUS_INTERRUPTS_ACK bit; one-cycle pulse.

Behaviour:
- Reset (RESET=0, async): pending=0, mask=all-ones (NUM_SRC bits), state=IDLE, active index=0, valid=0, CPU_IRQ_RAISE=0, SRC_IRQ_ACK=0, bus released (Z), edge history=0.
- Source capture:
  - Rising edge of SRC_IRQ_RAISE[i] detected at cycle n (registered previous value).
  - At n+1: pending[i]=1 and SRC_IRQ_ACK[i]=1 for exactly one cycle.
  - A level held high does not re-trigger; an edge on an already-pending source re-acks, pending stays 1.
  - Capture is independent of mask.
- Eligible = pending & mask.
- FSM states IDLE, RAISE, SERVICE:
  - IDLE: if eligible != 0, latch the winner into active and set valid=1; go to RAISE. CPU_IRQ_RAISE=1 from the next cycle. Minimum latency, source edge to CPU_IRQ_RAISE: 2 cycles.
  - RAISE: CPU_IRQ_RAISE held 1 until CPU_IRQ_ACK is sampled 1; then CPU_IRQ_RAISE=0 and go to SERVICE.
  - SERVICE: wait for an EOI write. On EOI: pending[active]=0, valid=0, go to IDLE. Re-arbitration is possible on the following cycle.
- Priority: fixed; lowest index wins.
- Register window (write when BUS_WE=1 and address matches):
  - D0 MASK, RW: bits NUM_SRC-1:0; upper bits read 0.
  - D1 PENDING, RO.
  - D2 VECTOR, RO: bit7=valid, bits2:0=active index.
  - D3 EOI, WO: any data value; reads return 0.
- Reads:
  - Address captured in cycle n with BUS_WE=0; data registered and driven on BUS_DATA during cycle n+1 only.
  - Addresses outside D0..D3 never drive the bus.
- Boundary and simultaneous cases:
  - CPU_IRQ_ACK in IDLE or SERVICE: ignored.
  - EOI outside SERVICE: ignored, including EOI in RAISE.
  - Source edge in the same cycle as EOI for that source: set wins; pending stays 1 with a fresh ack, and the source is re-arbitrated.
  - Active source masked during RAISE/SERVICE: service completes normally; mask only affects future arbitration.
  - Mask write and arbitration in the same cycle: arbitration uses the old mask.
  - All sources masked: remains in IDLE; pending keeps accumulating.
  - Reset asserted mid-RAISE: CPU_IRQ_RAISE drops asynchronously.

Optional Feature:
- Macro IRQ_ROUND_ROBIN_EN.
- Defined: rotating priority. Search starts at (last granted index + 1) mod NUM_SRC, with last-granted reset to NUM_SRC-1 so the first search starts at 0. Last-granted updates when a source is accepted in IDLE.
- Undefined: fixed lowest-index priority; no rotation state is synthesized.

Test Plan:
1. Reset, then read D0/D1/D2 -> 8'h0F, 8'h00, 8'h00 (NUM_SRC=4); BUS_DATA Z on all other cycles.
2. Raise src2 at cycle n -> SRC_IRQ_ACK[2] pulse at n+1; CPU_IRQ_RAISE=1 from n+2; CPU_IRQ_ACK -> RAISE low; read D2=8'h82; write D3 -> D1=8'h00, D2=8'h00.
3. Raise src1 and src3 together, fixed priority -> D2=8'h81 first; after EOI, D2=8'h83 with a second CPU_IRQ_RAISE. With IRQ_ROUND_ROBIN_EN and prior grant=1, src3 wins first.
4. Write D0=8'h0E, then raise src0 -> D1=8'h01, no CPU_IRQ_RAISE. Write D0=8'h0F -> CPU_IRQ_RAISE within 2 cycles.
5. EOI written during RAISE -> ignored; D1 unchanged. src0 edge coincident with src0 EOI -> D1 bit0 stays 1, new ack pulse, re-raise.
6. Assert RESET low while CPU_IRQ_RAISE=1 -> raise drops immediately; D1=0 after release; a level held through reset does not re-trigger without a new edge.
